// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl_if : hazard inputs and stage strobes of the pipeline ctrl |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
);
   logic [RA_W-1:0]  id_rs1;
   logic [RA_W-1:0]  id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             ex_is_load;
   logic [RA_W-1:0]  ex_rd;
   logic             ex_br_taken;
   logic             ex_ebreak;
   logic             mem_req;
   logic             mem_ready;
   logic             resume;
   logic             pc_wen;
   logic             if_id_wen;
   logic             id_ex_wen;
   logic             ex_mem_wen;
   logic             mem_wb_wen;
   logic             if_id_clear;
   logic             id_ex_clear;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
             ex_br_taken, ex_ebreak, mem_req, mem_ready, resume,
      input  pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
             if_id_clear, id_ex_clear, halted, stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
             ex_br_taken, ex_ebreak, mem_req, mem_ready, resume,
      output pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
             if_id_clear, id_ex_clear, halted, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl : stage write-enable / bubble sequencer for 5-stage pipe  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
) (
   input  wire              clk,
   input  wire              rstn,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_HALT     = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   state_t           r_state, w_state_nxt;
   logic             r_flush_pend, w_flush_pend_nxt;
   logic             r_halted, w_halted_nxt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_lu;
   logic w_pc_wen, w_if_id_wen, w_id_ex_wen, w_ex_mem_wen, w_mem_wb_wen;
   logic w_if_id_clear, w_id_ex_clear;

   assign w_lu = bus.ex_is_load && (bus.ex_rd != '0) &&
                 ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                  (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_RUN;
         r_flush_pend <= 1'b0;
         r_halted     <= 1'b0;
         r_stall_cnt  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_flush_pend <= w_flush_pend_nxt;
         r_halted     <= w_halted_nxt;
         if (!w_pc_wen && (r_stall_cnt != c_cnt_max))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_flush_pend_nxt = r_flush_pend;
      w_halted_nxt     = r_halted;
      w_pc_wen         = 1'b1;
      w_if_id_wen      = 1'b1;
      w_id_ex_wen      = 1'b1;
      w_ex_mem_wen     = 1'b1;
      w_mem_wb_wen     = 1'b1;
      w_if_id_clear    = 1'b0;
      w_id_ex_clear    = 1'b0;

      case (r_state)
         S_RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               {w_pc_wen, w_if_id_wen, w_id_ex_wen, w_ex_mem_wen, w_mem_wb_wen} = '0;
               w_flush_pend_nxt = bus.ex_br_taken;
               w_state_nxt      = S_MEM_WAIT;
            end else if (bus.ex_ebreak) begin
               w_pc_wen      = 1'b0;
               w_if_id_wen   = 1'b0;
               w_id_ex_clear = 1'b1;
               w_halted_nxt  = 1'b1;
               w_state_nxt   = S_HALT;
            end else if (bus.ex_br_taken) begin
               w_if_id_clear = 1'b1;
               w_id_ex_clear = 1'b1;
            end else if (w_lu) begin
               w_pc_wen      = 1'b0;
               w_if_id_wen   = 1'b0;
               w_id_ex_clear = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (!bus.mem_ready) begin
               {w_pc_wen, w_if_id_wen, w_id_ex_wen, w_ex_mem_wen, w_mem_wb_wen} = '0;
               w_flush_pend_nxt = r_flush_pend || bus.ex_br_taken;
            end else begin
               // A branch seen during the stall takes effect in the release cycle.
               if (r_flush_pend || bus.ex_br_taken) begin
                  w_if_id_clear = 1'b1;
                  w_id_ex_clear = 1'b1;
               end else if (w_lu) begin
                  w_pc_wen      = 1'b0;
                  w_if_id_wen   = 1'b0;
                  w_id_ex_clear = 1'b1;
               end
               w_flush_pend_nxt = 1'b0;
               w_state_nxt      = S_RUN;
            end
         end
         S_HALT: begin
            w_pc_wen      = 1'b0;
            w_if_id_wen   = 1'b0;
            w_id_ex_clear = 1'b1;
            if (bus.resume) begin
               w_halted_nxt = 1'b0;
               w_state_nxt  = S_RUN;
            end
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   assign bus.pc_wen      = w_pc_wen;
   assign bus.if_id_wen   = w_if_id_wen;
   assign bus.id_ex_wen   = w_id_ex_wen;
   assign bus.ex_mem_wen  = w_ex_mem_wen;
   assign bus.mem_wb_wen  = w_mem_wb_wen;
   assign bus.if_id_clear = w_if_id_clear;
   assign bus.id_ex_clear = w_id_ex_clear;
   assign bus.halted      = r_halted;
   assign bus.stall_cnt   = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed scenarios plus randomized model comparison  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;
   localparam int RA_W    = 5;
   localparam int CNT_W   = 5;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // strobe vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_clr, id_ex_clr}
   localparam logic [6:0] c_norm  = 7'b1111100;
   localparam logic [6:0] c_front = 7'b0011101;
   localparam logic [6:0] c_flush = 7'b1111111;
   localparam logic [6:0] c_stall = 7'b0000000;

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_bad;

   // reference model state
   bit m_wait, m_halt, m_pend;
   int m_cnt;

   pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] obs();
      return {bus.pc_wen, bus.if_id_wen, bus.id_ex_wen, bus.ex_mem_wen,
              bus.mem_wb_wen, bus.if_id_clear, bus.id_ex_clear};
   endfunction

   task automatic idle();
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
      bus.ex_is_load = 0; bus.ex_rd = '0; bus.ex_br_taken = 0; bus.ex_ebreak = 0;
      bus.mem_req = 0; bus.mem_ready = 0; bus.resume = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected strobes from the rules: the whole pipe freezes on a memory wait,
   // the front end freezes (with a bubble) on a halt or load-use, a branch flushes.
   function automatic logic [6:0] model_strobes();
      bit lu;
      lu = bus.ex_is_load && (bus.ex_rd != 0) &&
           ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
      if (m_halt) return c_front;
      if (m_wait) begin
         if (!bus.mem_ready) return c_stall;
         if (m_pend || bus.ex_br_taken) return c_flush;
         return lu ? c_front : c_norm;
      end
      if (bus.mem_req && !bus.mem_ready) return c_stall;
      if (bus.ex_ebreak) return c_front;
      if (bus.ex_br_taken) return c_flush;
      return lu ? c_front : c_norm;
   endfunction

   task automatic model_advance(input logic [6:0] strobes);
      if (strobes[6] == 1'b0 && m_cnt < CNT_MAX) m_cnt++;
      if (m_halt) begin
         if (bus.resume) m_halt = 0;
      end else if (m_wait) begin
         if (!bus.mem_ready) m_pend = m_pend | bus.ex_br_taken;
         else begin m_pend = 0; m_wait = 0; end
      end else if (bus.mem_req && !bus.mem_ready) begin
         m_wait = 1; m_pend = bus.ex_br_taken;
      end else if (bus.ex_ebreak) begin
         m_halt = 1;
      end
   endtask

   task automatic test_reset();
      idle();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm || bus.halted !== 1'b0 || bus.stall_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset: strobes=%b halted=%b cnt=%0d want %b 0 0",
                  obs(), bus.halted, bus.stall_cnt, c_norm);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      bus.ex_is_load = 1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_front) begin
         n_bad++; $display("FAIL load_use_stall: got %b want %b", obs(), c_front);
      end
      tick();
      idle();
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm || bus.stall_cnt !== 5'd1) begin
         n_bad++; $display("FAIL load_use_one_bubble: got %b cnt=%0d want %b cnt=1",
                           obs(), bus.stall_cnt, c_norm);
      end
      tick();
      bus.ex_is_load = 1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm) begin
         n_bad++; $display("FAIL load_use_x0: got %b want %b", obs(), c_norm);
      end
      tick();
      idle();
      @(negedge clk);
      n_cmp++;
      if (bus.stall_cnt !== 5'd1) begin
         n_bad++; $display("FAIL load_use_x0_cnt: got %0d want 1", bus.stall_cnt);
      end
   endtask

   task automatic test_branch();
      tick();
      bus.ex_br_taken = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_flush) begin
         n_bad++; $display("FAIL branch: got %b want %b", obs(), c_flush);
      end
      tick();
      idle();
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm || bus.stall_cnt !== 5'd1) begin
         n_bad++; $display("FAIL branch_after: got %b cnt=%0d want %b cnt=1",
                           obs(), bus.stall_cnt, c_norm);
      end
   endtask

   task automatic test_mem_wait();
      tick();
      bus.mem_req = 1; bus.mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs() !== c_stall) begin
            n_bad++; $display("FAIL mem_wait_%0d: got %b want %b", i, obs(), c_stall);
         end
         tick();
      end
      bus.mem_ready = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm) begin
         n_bad++; $display("FAIL mem_ready: got %b want %b", obs(), c_norm);
      end
      tick();
      idle();
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm || bus.stall_cnt !== 5'd4) begin
         n_bad++; $display("FAIL mem_back_to_run: got %b cnt=%0d want %b cnt=4",
                           obs(), bus.stall_cnt, c_norm);
      end
   endtask

   task automatic test_deferred_flush();
      tick();
      bus.mem_req = 1; bus.mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         bus.ex_br_taken = (i == 1);
         @(negedge clk);
         n_cmp++;
         if (obs() !== c_stall) begin
            n_bad++; $display("FAIL defer_wait_%0d: got %b want %b", i, obs(), c_stall);
         end
         tick();
      end
      bus.ex_br_taken = 0; bus.mem_ready = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_flush) begin
         n_bad++; $display("FAIL defer_flush: got %b want %b", obs(), c_flush);
      end
      tick();
      idle();
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm || bus.stall_cnt !== 5'd7) begin
         n_bad++; $display("FAIL defer_after: got %b cnt=%0d want %b cnt=7",
                           obs(), bus.stall_cnt, c_norm);
      end
   endtask

   task automatic test_halt();
      tick();
      bus.ex_ebreak = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_front || bus.halted !== 1'b0) begin
         n_bad++; $display("FAIL ebreak: got %b halted=%b want %b 0", obs(), bus.halted, c_front);
      end
      tick();
      bus.ex_ebreak = 0;
      for (int i = 0; i < 10; i++) begin
         bus.ex_ebreak = (i == 4);
         @(negedge clk);
         n_cmp++;
         if (obs() !== c_front || bus.halted !== 1'b1) begin
            n_bad++; $display("FAIL halt_%0d: got %b halted=%b want %b 1",
                              i, obs(), bus.halted, c_front);
         end
         tick();
      end
      bus.ex_ebreak = 0; bus.resume = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_front || bus.halted !== 1'b1) begin
         n_bad++; $display("FAIL resume_cycle: got %b halted=%b want %b 1",
                           obs(), bus.halted, c_front);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm || bus.halted !== 1'b0 || bus.stall_cnt !== 5'd19) begin
         n_bad++; $display("FAIL resumed: got %b halted=%b cnt=%0d want %b 0 19",
                           obs(), bus.halted, bus.stall_cnt, c_norm);
      end
      tick();
      idle();
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm || bus.halted !== 1'b0) begin
         n_bad++; $display("FAIL resume_in_run: got %b halted=%b want %b 0",
                           obs(), bus.halted, c_norm);
      end
   endtask

   task automatic test_reset_mid_wait();
      tick();
      bus.mem_req = 1; bus.mem_ready = 0; bus.ex_br_taken = 1;
      tick();
      bus.ex_br_taken = 0;
      tick();
      rstn = 1'b0;
      idle();
      #1;
      n_cmp++;
      if (obs() !== c_norm || bus.halted !== 1'b0 || bus.stall_cnt !== '0) begin
         n_bad++; $display("FAIL async_reset: got %b halted=%b cnt=%0d want %b 0 0",
                           obs(), bus.halted, bus.stall_cnt, c_norm);
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      bus.mem_ready = 1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== c_norm) begin
         n_bad++; $display("FAIL reset_drops_flush: got %b want %b", obs(), c_norm);
      end
      tick();
      idle();
   endtask

   task automatic test_saturate();
      bus.ex_is_load = 1; bus.ex_rd = 5'd3; bus.id_rs2 = 5'd3; bus.id_use_rs2 = 1;
      repeat (20) tick();
      @(negedge clk);
      n_cmp++;
      if (bus.stall_cnt !== 5'd20) begin
         n_bad++; $display("FAIL cnt_mid: got %0d want 20", bus.stall_cnt);
      end
      repeat (20) tick();
      @(negedge clk);
      n_cmp++;
      if (bus.stall_cnt !== 5'(CNT_MAX)) begin
         n_bad++; $display("FAIL cnt_saturate: got %0d want %0d", bus.stall_cnt, CNT_MAX);
      end
      tick();
      idle();
      tick();
      @(negedge clk);
      n_cmp++;
      if (bus.stall_cnt !== 5'(CNT_MAX)) begin
         n_bad++; $display("FAIL cnt_hold: got %0d want %0d", bus.stall_cnt, CNT_MAX);
      end
   endtask

   task automatic test_random();
      logic [6:0] exp_s;
      idle();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      m_wait = 0; m_halt = 0; m_pend = 0; m_cnt = 0;
      tick();
      for (int c = 0; c < 600; c++) begin
         bus.id_rs1      = 5'($urandom_range(0, 3));
         bus.id_rs2      = 5'($urandom_range(0, 3));
         bus.ex_rd       = 5'($urandom_range(0, 3));
         bus.id_use_rs1  = 1'($urandom_range(0, 1));
         bus.id_use_rs2  = 1'($urandom_range(0, 1));
         bus.ex_is_load  = 1'($urandom_range(0, 1));
         bus.ex_br_taken = ($urandom_range(0, 4) == 0);
         bus.ex_ebreak   = ($urandom_range(0, 24) == 0);
         bus.mem_req     = ($urandom_range(0, 3) == 0);
         bus.mem_ready   = ($urandom_range(0, 2) != 0);
         bus.resume      = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         exp_s = model_strobes();
         n_cmp++;
         if (obs() !== exp_s || bus.halted !== m_halt || bus.stall_cnt !== 5'(m_cnt)) begin
            n_bad++;
            $display("FAIL random_cycle_%0d: got %b halted=%b cnt=%0d want %b halted=%b cnt=%0d",
                     c, obs(), bus.halted, bus.stall_cnt, exp_s, m_halt, m_cnt);
         end
         model_advance(exp_s);
         tick();
      end
      idle();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rstn  = 1'b0;
      idle();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_deferred_flush();
      test_halt();
      test_reset_mid_wait();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
